vram_port_arbiter: RTL and testbench

Arbitrates the single-port 600-word text VRAM between the AXI4-Lite register front end and the character-fetch port of the text renderer. The renderer gets strict priority and a fixed 2-cycle read latency. AXI accesses use the idle slots, one transaction outstanding at a time, with byte-strobe writes and a held response. The block sits between the AXI slave logic and the VRAM BRAM primitive inside the HDMI text controller IP.

---
 rtl/vram_port_arbiter_if.sv | 26 ++
 rtl/vram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// AXI-side request/response channel between the register front end and the
// VRAM port arbiter. The front end is the master; the arbiter is the slave.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 10
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares the single-port text VRAM between the renderer (strict priority,
// fixed 2-cycle fetch latency) and AXI accesses that fill the idle slots.
module vram_port_arbiter #(
    parameter int DEPTH  = 600,
    parameter int ADDR_W = 10
) (
    input  logic                axi_aclk,
    input  logic                reset,
    vram_port_arbiter_if.slave  axi,
    input  logic                rnd_req,
    input  logic [ADDR_W-1:0]   rnd_addr,
    output logic [31:0]         rnd_rdata,
    output logic                rnd_rvalid,
    output logic                bram_en,
    output logic [3:0]          bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [31:0]         bram_din,
    input  logic [31:0]         bram_dout,
    output logic [15:0]         stall_count
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic                hs_s;
    logic                req_ready_s;
    logic                rsp_valid_s;
    logic                ax_we_r;
    logic                ax_ok_r;
    logic [31:0]         rsp_rdata_r;
    logic                rsp_err_r;
    logic                rnd_p1_r;
    logic                rnd_ok_r;
    logic                rnd_rvalid_r;
    logic [31:0]         rnd_rdata_r;
    logic [15:0]         stall_r;
    logic                bram_en_s;
    logic [3:0]          bram_we_s;
    logic [ADDR_W-1:0]   bram_addr_s;
    logic [31:0]         bram_din_s;

    // Next-state and handshake decode for the AXI access sequencer.
    always_comb begin
        state_s     = state_r;
        hs_s        = 1'b0;
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = !rnd_req && !reset;
                hs_s        = axi.req_valid && req_ready_s;
                if (hs_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_s = !reset;
                if (axi.rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // BRAM port mux: the renderer always owns the port when it asks for it.
    always_comb begin
        bram_en_s   = 1'b0;
        bram_we_s   = 4'h0;
        bram_addr_s = {ADDR_W{1'b0}};
        bram_din_s  = 32'h0000_0000;
        if (reset) begin
            bram_en_s = 1'b0;
            bram_we_s = 4'h0;
        end else if (rnd_req) begin
            bram_en_s   = in_range(rnd_addr);
            bram_addr_s = rnd_addr;
        end else if (hs_s) begin
            bram_en_s   = in_range(axi.req_addr);
            bram_addr_s = axi.req_addr;
            bram_din_s  = axi.req_wdata;
            bram_we_s   = axi.req_we ? axi.req_wstrb : 4'h0;
        end else begin
            bram_en_s = 1'b0;
            bram_we_s = 4'h0;
        end
    end

    // AXI transaction attributes and response capture at the end of WAIT.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            ax_we_r     <= 1'b0;
            ax_ok_r     <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            if (hs_s) begin
                ax_we_r <= axi.req_we;
                ax_ok_r <= in_range(axi.req_addr);
            end
            if (state_r == ST_WAIT) begin
                rsp_err_r   <= !ax_ok_r;
                rsp_rdata_r <= (ax_ok_r && !ax_we_r) ? bram_dout : 32'h0000_0000;
            end
        end
    end

    // Renderer fetch pipeline; out-of-range fetches return zero instead of stale BRAM output.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            rnd_p1_r     <= 1'b0;
            rnd_ok_r     <= 1'b0;
            rnd_rvalid_r <= 1'b0;
            rnd_rdata_r  <= 32'h0000_0000;
        end else begin
            rnd_p1_r     <= rnd_req;
            rnd_ok_r     <= rnd_req && in_range(rnd_addr);
            rnd_rvalid_r <= rnd_p1_r;
            rnd_rdata_r  <= rnd_ok_r ? bram_dout : 32'h0000_0000;
        end
    end

    // Saturating count of idle cycles where a pending AXI request lost to the renderer.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            stall_r <= 16'h0000;
        end else if ((state_r == ST_IDLE) && axi.req_valid && rnd_req && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'h0001;
        end
    end

    assign axi.req_ready = req_ready_s;
    assign axi.rsp_valid = rsp_valid_s;
    assign axi.rsp_rdata = rsp_rdata_r;
    assign axi.rsp_err   = rsp_err_r;
    assign rnd_rvalid    = rnd_rvalid_r;
    assign rnd_rdata     = rnd_rdata_r;
    assign stall_count   = stall_r;
    assign bram_en       = bram_en_s;
    assign bram_we       = bram_we_s;
    assign bram_addr     = bram_addr_s;
    assign bram_din      = bram_din_s;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: BRAM model, reference model of the arbitration
// rules checked every cycle, directed scenarios plus randomized traffic.
module tb_vram_port_arbiter;
    localparam int DEPTH  = 600;
    localparam int ADDR_W = 10;

    logic              axi_aclk = 1'b0;
    logic              reset    = 1'b1;
    logic              rnd_req  = 1'b0;
    logic [ADDR_W-1:0] rnd_addr = 10'd0;
    logic [31:0]       rnd_rdata;
    logic              rnd_rvalid;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout = 32'h0;
    logic [15:0]       stall_count;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W)) axi ();

    vram_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .axi_aclk   (axi_aclk),
        .reset      (reset),
        .axi        (axi.slave),
        .rnd_req    (rnd_req),
        .rnd_addr   (rnd_addr),
        .rnd_rdata  (rnd_rdata),
        .rnd_rvalid (rnd_rvalid),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .stall_count(stall_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // BRAM primitive model: read-first, registered output, noise when not enabled.
    logic [31:0] bram_mem [0:DEPTH-1];
    always @(posedge axi_aclk) begin
        if (bram_en && (int'(bram_addr) < DEPTH)) begin
            bram_dout <= bram_mem[bram_addr];
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
            end
        end else begin
            bram_dout <= $urandom;
        end
    end

    // Reference model state.
    typedef struct { int due; logic [31:0] data; } rexp_t;
    rexp_t       rq [$];
    logic [31:0] ref_mem [0:DEPTH-1];
    int          cyc     = 0;
    bit          m_busy  = 1'b0;
    int          m_acc   = 0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;
    int          m_stall = 0;
    bit          exp_hs;
    bit          exp_rv;

    function automatic bit in_rng(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [ADDR_W-1:0] a);
        if (int'(a) < DEPTH) return ref_mem[a];
        return 32'h0;
    endfunction

    // Per-cycle comparison of DUT outputs against the reference model.
    always @(negedge axi_aclk) begin
        cyc++;
        if (reset) begin
            chk("rst_req_ready", {31'b0, axi.req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'b0, axi.rsp_valid}, 32'd0);
            chk("rst_bram_en",   {31'b0, bram_en}, 32'd0);
            chk("rst_bram_we",   {28'b0, bram_we}, 32'd0);
            m_busy  = 1'b0;
            m_stall = 0;
            rq.delete();
        end else begin
            exp_hs = !m_busy && !rnd_req && axi.req_valid;
            exp_rv = m_busy && (cyc >= m_acc + 2);
            chk("req_ready", {31'b0, axi.req_ready}, {31'b0, !m_busy && !rnd_req});
            chk("rsp_valid", {31'b0, axi.rsp_valid}, {31'b0, exp_rv});
            if (exp_rv) begin
                chk("rsp_rdata", axi.rsp_rdata, m_rdata);
                chk("rsp_err",   {31'b0, axi.rsp_err}, {31'b0, m_err});
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("rnd_rvalid", {31'b0, rnd_rvalid}, 32'd1);
                chk("rnd_rdata",  rnd_rdata, rq[0].data);
                void'(rq.pop_front());
            end else begin
                chk("rnd_rvalid_idle", {31'b0, rnd_rvalid}, 32'd0);
            end
            chk("stall_count", {16'b0, stall_count}, (m_stall > 65535) ? 32'd65535 : 32'(m_stall));
            if (rnd_req) begin
                chk("bram_en_rnd", {31'b0, bram_en}, {31'b0, in_rng(rnd_addr)});
                chk("bram_we_rnd", {28'b0, bram_we}, 32'd0);
                if (in_rng(rnd_addr)) chk("bram_addr_rnd", {22'b0, bram_addr}, {22'b0, rnd_addr});
            end else if (exp_hs) begin
                chk("bram_en_axi", {31'b0, bram_en}, {31'b0, in_rng(axi.req_addr)});
                chk("bram_we_axi", {28'b0, bram_we}, axi.req_we ? {28'b0, axi.req_wstrb} : 32'd0);
                if (in_rng(axi.req_addr)) begin
                    chk("bram_addr_axi", {22'b0, bram_addr}, {22'b0, axi.req_addr});
                    if (axi.req_we) chk("bram_din", bram_din, axi.req_wdata);
                end
            end else begin
                chk("bram_en_idle", {31'b0, bram_en}, 32'd0);
                chk("bram_we_idle", {28'b0, bram_we}, 32'd0);
            end
            // Advance the model to the next cycle.
            if (rnd_req) rq.push_back('{cyc + 2, rd_ref(rnd_addr)});
            if (!m_busy && axi.req_valid && rnd_req) m_stall++;
            if (exp_rv && axi.rsp_ready) m_busy = 1'b0;
            if (exp_hs) begin
                m_busy  = 1'b1;
                m_acc   = cyc;
                m_err   = !in_rng(axi.req_addr);
                m_rdata = (!axi.req_we) ? rd_ref(axi.req_addr) : 32'h0;
                if (axi.req_we && in_rng(axi.req_addr)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (axi.req_wstrb[b]) ref_mem[axi.req_addr][8*b +: 8] = axi.req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge axi_aclk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns in the cycle after the handshake.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        axi.req_valid = 1'b1;
        axi.req_we    = we;
        axi.req_addr  = a;
        axi.req_wdata = d;
        axi.req_wstrb = s;
        @(negedge axi_aclk);
        while (!axi.req_ready && n < 500) begin
            next_cycle();
            @(negedge axi_aclk);
            n++;
        end
        chk("accept_in_time", {31'b0, axi.req_ready}, 32'd1);
        next_cycle();
        axi.req_valid = 1'b0;
    endtask

    // Wait for the response (latency counted from the handshake), holding rsp_ready low for 'hold' RESP cycles.
    task automatic collect(input int hold, output logic [31:0] rd, output logic er, output int lat);
        int n;
        n   = 0;
        lat = 1;
        axi.rsp_ready = (hold == 0);
        @(negedge axi_aclk);
        while (!axi.rsp_valid && n < 50) begin
            next_cycle();
            @(negedge axi_aclk);
            lat++;
            n++;
        end
        chk("rsp_in_time", {31'b0, axi.rsp_valid}, 32'd1);
        rd = axi.rsp_rdata;
        er = axi.rsp_err;
        if (hold > 0) begin
            for (int h = 1; h < hold; h++) begin
                next_cycle();
                @(negedge axi_aclk);
                chk("hold_rsp_valid", {31'b0, axi.rsp_valid}, 32'd1);
                chk("hold_req_ready", {31'b0, axi.req_ready}, 32'd0);
            end
            next_cycle();
            axi.rsp_ready = 1'b1;
            @(negedge axi_aclk);
        end
        next_cycle();
    endtask

    task automatic xfer(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, output logic [31:0] rd, output logic er);
        int lat;
        issue(we, a, d, s);
        collect(hold, rd, er, lat);
        chk("rsp_latency", 32'(lat), 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          done;
        for (int i = 0; i < DEPTH; i++) begin
            bram_mem[i] = $urandom;
            ref_mem[i]  = bram_mem[i];
        end
        axi.req_valid = 1'b0;
        axi.req_we    = 1'b0;
        axi.req_addr  = 10'd0;
        axi.req_wdata = 32'h0;
        axi.req_wstrb = 4'h0;
        axi.rsp_ready = 1'b1;
        repeat (3) @(posedge axi_aclk);
        #1 reset = 1'b0;

        // Reset values once reset is released.
        @(negedge axi_aclk);
        chk("post_rst_ready",   {31'b0, axi.req_ready}, 32'd1);
        chk("post_rst_stall",   {16'b0, stall_count}, 32'd0);
        chk("post_rst_rvalid",  {31'b0, rnd_rvalid}, 32'd0);
        chk("post_rst_rnddata", rnd_rdata, 32'd0);
        chk("post_rst_rspdata", axi.rsp_rdata, 32'd0);
        chk("post_rst_rsperr",  {31'b0, axi.rsp_err}, 32'd0);
        next_cycle();

        // Full-word write then read back.
        xfer(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 0, rd, er);
        xfer(1'b0, 10'd5, 32'h0, 4'h0, 0, rd, er);
        chk("rd5_data", rd, 32'hDEADBEEF);
        chk("rd5_err",  {31'b0, er}, 32'd0);

        // Byte-strobe merge.
        xfer(1'b1, 10'd7, 32'h11223344, 4'hF, 0, rd, er);
        xfer(1'b1, 10'd7, 32'hAABBCCDD, 4'b0101, 0, rd, er);
        xfer(1'b0, 10'd7, 32'h0, 4'h0, 0, rd, er);
        chk("rd7_strb", rd, 32'h11BB33DD);

        // Renderer burst starves a held AXI read.
        axi.req_valid = 1'b1;
        axi.req_we    = 1'b0;
        axi.req_addr  = 10'd7;
        for (int i = 0; i < 10; i++) begin
            rnd_req  = 1'b1;
            rnd_addr = 10'(i);
            @(negedge axi_aclk);
            chk("burst_req_ready", {31'b0, axi.req_ready}, 32'd0);
            if (i >= 2) chk("burst_rvalid", {31'b0, rnd_rvalid}, 32'd1);
            next_cycle();
        end
        rnd_req = 1'b0;
        @(negedge axi_aclk);
        chk("burst_accept", {31'b0, axi.req_ready}, 32'd1);
        chk("burst_stall",  {16'b0, stall_count}, 32'd10);
        chk("burst_rv8",    {31'b0, rnd_rvalid}, 32'd1);
        next_cycle();
        axi.req_valid = 1'b0;
        @(negedge axi_aclk);
        chk("burst_rv9", {31'b0, rnd_rvalid}, 32'd1);
        #1;
        collect(0, rd, er, lat);
        chk("burst_rd7", rd, 32'h11BB33DD);

        // Out-of-range AXI read and renderer fetch.
        xfer(1'b0, 10'd600, 32'h0, 4'h0, 0, rd, er);
        chk("oor_err",  {31'b0, er}, 32'd1);
        chk("oor_data", rd, 32'd0);
        rnd_req  = 1'b1;
        rnd_addr = 10'd1023;
        @(negedge axi_aclk);
        chk("oor_rnd_en", {31'b0, bram_en}, 32'd0);
        next_cycle();
        rnd_req = 1'b0;
        next_cycle();
        @(negedge axi_aclk);
        chk("oor_rnd_rv",   {31'b0, rnd_rvalid}, 32'd1);
        chk("oor_rnd_data", rnd_rdata, 32'd0);
        next_cycle();

        // Held response with a competing request pending.
        issue(1'b0, 10'd5, 32'h0, 4'h0);
        axi.req_valid = 1'b1;
        axi.req_we    = 1'b0;
        axi.req_addr  = 10'd7;
        collect(5, rd, er, lat);
        chk("hold_data", rd, 32'hDEADBEEF);
        issue(1'b0, 10'd7, 32'h0, 4'h0);
        collect(0, rd, er, lat);
        chk("after_hold_data", rd, 32'h11BB33DD);

        // Reset during WAIT drops the response; reset during a write handshake blocks the write.
        issue(1'b0, 10'd5, 32'h0, 4'h0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        repeat (3) begin
            @(negedge axi_aclk);
            chk("rst_no_rsp", {31'b0, axi.rsp_valid}, 32'd0);
            next_cycle();
        end
        chk("rst_stall_zero", {16'b0, stall_count}, 32'd0);
        axi.req_valid = 1'b1;
        axi.req_we    = 1'b1;
        axi.req_addr  = 10'd5;
        axi.req_wdata = 32'h0BADF00D;
        axi.req_wstrb = 4'hF;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        axi.req_valid = 1'b0;
        xfer(1'b0, 10'd5, 32'h0, 4'h0, 0, rd, er);
        chk("rst_write_blocked", rd, 32'hDEADBEEF);

        // Randomized AXI traffic against random renderer fetches.
        done = 1'b0;
        fork
            begin
                for (int t = 0; t < 150; t++) begin
                    logic [ADDR_W-1:0] a;
                    a = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(600, 1023)) : 10'($urandom_range(0, 15));
                    xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), rd, er);
                    repeat ($urandom_range(0, 2)) next_cycle();
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 20000 && !done; c++) begin
                    next_cycle();
                    rnd_req  = ($urandom_range(0, 2) == 0);
                    rnd_addr = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
                end
                rnd_req = 1'b0;
            end
        join
        repeat (5) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
